// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: FSM encodings and count-width helper for serial_subtractor.
package serial_sub_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit cell, diff = a - b - bin with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, valid/ready on both sides.
// SERIAL_SUBTRACTOR_OVERFLOW_EN adds a registered signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [CW-1:0]    count;
   logic             borrow, d, bo, last;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic             a_msb, b_msb;
`endif
   full_subtractor u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (borrow),
      .diff(d),
      .bout(bo)
   );
   assign last      = count == LAST;
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = in_valid ? SHIFT : IDLE;
         SHIFT:   state_d = last ? DONE : SHIFT;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         diff   <= '0;
         count  <= '0;
         borrow <= 1'b0;
         bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else if (state_q == IDLE && in_valid) begin
         a_sh   <= a;
         b_sh   <= b;
         borrow <= bin;
         count  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
`endif
      end else if (state_q == SHIFT) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         diff   <= {d, diff[WIDTH-1:1]};
         borrow <= bo;
         count  <= last ? '0 : count + 1'b1;
         if (last) begin
            bout <= bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            // d is the final result MSB on this edge
            ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       in_ready, out_valid, bout;
   logic [7:0] diff;
   logic       ovf;
   logic       fa, fb, fbin, fd, fbo;
   int         tests = 0, fails = 0;
   serial_subtractor #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .bout     (bout)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      ,
      .ovf      (ovf)
`endif
   );
`ifndef SERIAL_SUBTRACTOR_OVERFLOW_EN
   assign ovf = 1'b0;
`endif
   full_subtractor u_cell (.a(fa), .b(fb), .bin(fbin), .diff(fd), .bout(fbo));
   always #5 clk = ~clk;

   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input int stall,
                        output logic [7:0] rd, output logic rb, output logic ro, output int lat, output logic to);
      int n;
      to = 1'b0;
      n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) to = 1'b1;
      a = ia; b = ib; bin = ibin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) to = 1'b1;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      rd = diff; rb = bout; ro = ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b, want 1 0 00 0 0", in_ready, out_valid, diff, bout, ovf);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_cell;
      for (int i = 0; i < 8; i++) begin
         int r;
         fa = i[2]; fb = i[1]; fbin = i[0];
         r = int'(fa) - int'(fb) - int'(fbin);
         #1;
         tests++;
         if (fd !== r[0] || fbo !== (r < 0)) begin
            fails++;
            $display("FAIL cell %b%b%b: diff=%b bout=%b, want %b %b", fa, fb, fbin, fd, fbo, r[0], r < 0);
         end
      end
   endtask

   task automatic test_directed;
      logic [7:0] ta [4] = '{8'h05, 8'h00, 8'h80, 8'h3C};
      logic [7:0] tb [4] = '{8'h03, 8'h01, 8'h80, 8'h3C};
      logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] ed [4] = '{8'h02, 8'hFF, 8'hFF, 8'h00};
      logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         logic [7:0] rd;
         logic       rb, ro, to;
         int         lat;
         do_op(ta[i], tb[i], tc[i], 0, rd, rb, ro, lat, to);
         tests++;
         if (to || rd !== ed[i] || rb !== eb[i] || lat != 8) begin
            fails++;
            $display("FAIL directed %h-%h-%b: diff=%h bout=%b lat=%0d to=%b, want %h %b 8", ta[i], tb[i], tc[i], rd, rb, lat, to, ed[i], eb[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      int n;
      @(posedge clk); #1;
      a = 8'h10; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin a = 8'hAA; b = 8'h00; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(posedge clk); #1;
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h0F || bout !== 1'b0) begin
            fails++;
            $display("FAIL stall%0d: out_valid=%b in_ready=%b diff=%h bout=%b, want 1 0 0f 0", i, out_valid, in_ready, diff, bout);
         end
      end
      a = 8'hAA; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [7:0] rd;
      logic       rb, ro, to;
      int         lat;
      @(posedge clk); #1;
      a = 8'h10; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || diff !== 8'h00 || in_ready !== 1'b1 || bout !== 1'b0) begin
         fails++;
         $display("FAIL midreset: out_valid=%b diff=%h in_ready=%b bout=%b, want 0 00 1 0", out_valid, diff, in_ready, bout);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL postreset: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      do_op(8'h10, 8'h01, 1'b0, 0, rd, rb, ro, lat, to);
      tests++;
      if (to || rd !== 8'h0F || rb !== 1'b0 || lat != 8) begin
         fails++;
         $display("FAIL afterreset: diff=%h bout=%b lat=%0d to=%b, want 0f 0 8", rd, rb, lat, to);
      end
   endtask

   task automatic test_random;
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ia, ib, rd, ed;
         logic       ic, rb, ro, to, eo;
         int         lat, r;
         ia = 8'($urandom); ib = 8'($urandom); ic = 1'($urandom);
         r = int'(ia) - int'(ib) - int'(ic);
         ed = r[7:0];
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         eo = (ia[7] != ib[7]) && (ed[7] != ia[7]);
`else
         eo = 1'b0;
`endif
         do_op(ia, ib, ic, int'($urandom_range(0, 3)), rd, rb, ro, lat, to);
         tests++;
         if (to || rd !== ed || rb !== (r < 0) || ro !== eo || lat != 8) begin
            fails++;
            bad++;
            if (bad <= 10)
               $display("FAIL random %h-%h-%b: diff=%h bout=%b ovf=%b lat=%0d to=%b, want %h %b %b 8", ia, ib, ic, rd, rb, ro, lat, to, ed, r < 0, eo);
         end
      end
   endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   task automatic test_ovf;
      logic [7:0] ta [3] = '{8'h80, 8'h7F, 8'h05};
      logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h03};
      logic [7:0] ed [3] = '{8'h7F, 8'h80, 8'h02};
      logic       eo [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         logic [7:0] rd;
         logic       rb, ro, to;
         int         lat;
         do_op(ta[i], tb[i], 1'b0, 1, rd, rb, ro, lat, to);
         tests++;
         if (to || rd !== ed[i] || ro !== eo[i]) begin
            fails++;
            $display("FAIL ovf %h-%h: diff=%h ovf=%b to=%b, want %h %b", ta[i], tb[i], rd, ro, to, ed[i], eo[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_cell;
      test_directed;
      test_backpressure;
      test_reset_mid;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      test_ovf;
`endif
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Built from a single 1-bit full-subtractor cell, the borrow-chain dual of the team's full adder.
- Sits between producer/consumer logic using valid/ready handshakes on both sides.
- Trades latency (WIDTH cycles) for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, bin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned/two's complement.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, internal shift registers/count/borrow=0.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state, with no combinational input-to-output path.
- IDLE: on edge with in_valid=1, capture a, b into shift registers, borrow<=bin, count<=0, go SHIFT. With in_valid=0, stay.
- SHIFT: each edge, cell computes d = a_sh[0]^b_sh[0]^borrow and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - borrow<=bo; a_sh, b_sh shift right; d shifts into diff at MSB (diff<={d, diff[WIDTH-1:1]}); count++.
  - On the edge where count==WIDTH-1: bout<=bo, go DONE.
- Latency: operands accepted at edge T0; out_valid high after edge T0+WIDTH, i.e. exactly WIDTH cycles.
- DONE: diff, bout held stable while out_valid=1 and out_ready=0 (unbounded backpressure). On edge with out_ready=1, go IDLE; in_ready high the next cycle.
- Throughput: one operation per WIDTH+2 cycles. No accept in DONE, even with simultaneous out_ready and in_valid.
- Inputs a/b/bin ignored outside IDLE; in_valid in SHIFT/DONE has no effect.
- Counter width: clog2(WIDTH), wraps to 0 on entering DONE.
- Reset mid-operation (any state): immediate abort to reset values; partial result discarded, never presented.
- Edge values: a=b, bin=0 gives diff=0, bout=0. 0-0 with bin=1 gives all-ones, bout=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined: extra output port ovf (1 bit), registered alongside bout on the final SHIFT edge. Reset 0; held in DONE.
  - ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Original a[MSB], b[MSB] are latched at capture for this purpose.
- Undefined: ovf port and its registers absent; all other behaviour identical.

Decomposition:
- Package serial_sub_pkg holds:
  - FSM state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - A clog2-based count-width constant function.
- One sub-module, full_subtractor: combinational 1-bit cell with ports a, b, bin, diff, bout. It is instantiated once and also unit-testable exhaustively, all 8 combinations, in the style of the adder bench.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; out_valid rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Also a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1.
- Backpressure: out_ready=0 for 5 cycles after completion of a=0x10, b=0x01 -> diff=0x0F held stable, out_valid=1, in_ready=0. Pulsed in_valid with a=0xAA ignored. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Assert rst 4 cycles into SHIFT -> out_valid=0, diff=0, in_ready=1 during/after reset. Next op a=0x10, b=0x01 -> diff=0x0F with normal 8-cycle latency.
- Random: 1000 random a/b/bin with random out_ready stalls, scoreboard against (a-b-bin) mod 256 and the unsigned borrow; zero mismatches.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
